// File: rtl/uart_mem_loader_pkg.sv
// Shared types and constants for the UART memory loader and the memory write decode.
package uart_mem_loader_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    localparam logic [1:0] MW_DWORD = 2'b11;
    localparam logic [1:0] MW_NONE  = 2'b00;

    // First byte of a dword lands in the most significant lane.
    function automatic int lane_lsb(input logic [2:0] lane);
        return (7 - int'(lane)) * 8;
    endfunction

endpackage

// File: rtl/uart_mem_loader_if.sv
// Memory write port driven by the loader while the CPU is held.
interface uart_mem_loader_if #(
    parameter int N = 64
);
    // memwrite qualifies dataadr/writedata for exactly one cycle per dword;
    // the memory has no backpressure, so there is no ready.
    logic [N-1:0] dataadr;
    logic [N-1:0] writedata;
    logic [1:0]   memwrite;

    modport master (
        output dataadr,
        output writedata,
        output memwrite
    );

    modport slave (
        input dataadr,
        input writedata,
        input memwrite
    );
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: rx synchronizer, baud counter and RX FSM.
// Emits one-cycle valid / frame-error pulses after the stop-bit sample.
module uart_rx_core
    import uart_mem_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      en,
    input  logic      rx,
    output logic [7:0] rx_byte,
    output logic      rx_valid,
    output logic      rx_ferr,
    output rx_state_e state
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    logic      rx_s1_q, rx_s1_d;
    logic      rx_s2_q, rx_s2_d;
    rx_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] byte_q, byte_d;
    logic      valid_q, valid_d;
    logic      ferr_q, ferr_d;

    always_comb begin
        rx_s1_d = rx;
        rx_s2_d = rx_s1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        // Disabling mid-frame simply abandons the frame.
        if (!en) begin
            state_d = RX_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                RX_IDLE: begin
                    cnt_d = '0;
                    if (!rx_s2_q) state_d = RX_START;
                end
                RX_START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_d   = '0;
                        bit_d   = '0;
                        state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_d   = '0;
                        shift_d = {rx_s2_q, shift_q[7:1]};
                        if (bit_q == 3'd7) state_d = RX_STOP;
                        else               bit_d   = bit_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_d   = '0;
                        state_d = RX_IDLE;
                        if (rx_s2_q) begin
                            byte_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            rx_s1_q <= rx_s1_d;
            rx_s2_q <= rx_s2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rx_byte  = byte_q;
    assign rx_valid = valid_q;
    assign rx_ferr  = ferr_q;
    assign state    = state_q;

endmodule

// File: rtl/uart_mem_loader.sv
// Loads a memory image received over UART: packs 8 bytes per dword (first byte
// in the top lane) and writes L consecutive dwords while holding the CPU.
module uart_mem_loader
    import uart_mem_loader_pkg::*;
#(
    parameter int N            = 64,
    parameter int L            = 128,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic              rx,
    uart_mem_loader_if.master mem,
    output logic              cpu_hold,
    output logic              done,
    output logic              frame_err,
    output logic [7:0]        rx_data,
    output logic [15:0]       byte_cnt,
    output rx_state_e         dbg_rx_state
);

    localparam int WI = (L > 1) ? $clog2(L) : 1;

    logic [7:0] core_byte;
    logic       core_valid;
    logic       core_ferr;

    logic          load_en_q, load_en_d;
    logic [WI-1:0] wr_idx_q, wr_idx_d;
    logic [2:0]    lane_q, lane_d;
    logic [N-1:0]  pack_q, pack_d;
    logic [N-1:0]  dataadr_q, dataadr_d;
    logic [N-1:0]  writedata_q, writedata_d;
    logic [1:0]    memwrite_q, memwrite_d;
    logic          done_q, done_d;
    logic          frame_err_q, frame_err_d;
    logic          cpu_hold_q, cpu_hold_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic [15:0]   byte_cnt_q, byte_cnt_d;
    logic          load_rise;

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (load_en & ~done_q),
        .rx      (rx),
        .rx_byte (core_byte),
        .rx_valid(core_valid),
        .rx_ferr (core_ferr),
        .state   (dbg_rx_state)
    );

    assign load_rise = load_en & ~load_en_q;

    always_comb begin
        load_en_d   = load_en;
        wr_idx_d    = wr_idx_q;
        lane_d      = lane_q;
        pack_d      = pack_q;
        dataadr_d   = dataadr_q;
        writedata_d = writedata_q;
        memwrite_d  = MW_NONE;
        done_d      = done_q;
        frame_err_d = frame_err_q;
        rx_data_d   = rx_data_q;
        byte_cnt_d  = byte_cnt_q;

        // A new load session restarts at dword 0; the last write stays visible.
        if (load_rise) begin
            wr_idx_d    = '0;
            lane_d      = '0;
            pack_d      = '0;
            byte_cnt_d  = '0;
            done_d      = 1'b0;
            frame_err_d = 1'b0;
        end else if (load_en) begin
            if (core_ferr) frame_err_d = 1'b1;
            if (core_valid) begin
                rx_data_d  = core_byte;
                byte_cnt_d = byte_cnt_q + 1'b1;
                if (lane_q == 3'd7) begin
                    writedata_d = {pack_q[N-1:8], core_byte};
                    dataadr_d   = N'({wr_idx_q, 3'b000});
                    memwrite_d  = MW_DWORD;
                    wr_idx_d    = wr_idx_q + 1'b1;
                    lane_d      = '0;
                    pack_d      = '0;
                    if (wr_idx_q == WI'(L - 1)) done_d = 1'b1;
                end else begin
                    pack_d[lane_lsb(lane_q) +: 8] = core_byte;
                    lane_d = lane_q + 1'b1;
                end
            end
        end else begin
            // Abort drops any partially packed dword.
            lane_d = '0;
            pack_d = '0;
        end

        cpu_hold_d = load_en & ~done_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_en_q   <= 1'b0;
            wr_idx_q    <= '0;
            lane_q      <= '0;
            pack_q      <= '0;
            dataadr_q   <= '0;
            writedata_q <= '0;
            memwrite_q  <= MW_NONE;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
            cpu_hold_q  <= 1'b0;
            rx_data_q   <= '0;
            byte_cnt_q  <= '0;
        end else begin
            load_en_q   <= load_en_d;
            wr_idx_q    <= wr_idx_d;
            lane_q      <= lane_d;
            pack_q      <= pack_d;
            dataadr_q   <= dataadr_d;
            writedata_q <= writedata_d;
            memwrite_q  <= memwrite_d;
            done_q      <= done_d;
            frame_err_q <= frame_err_d;
            cpu_hold_q  <= cpu_hold_d;
            rx_data_q   <= rx_data_d;
            byte_cnt_q  <= byte_cnt_d;
        end
    end

    assign mem.dataadr   = dataadr_q;
    assign mem.writedata = writedata_q;
    assign mem.memwrite  = memwrite_q;
    assign cpu_hold      = cpu_hold_q;
    assign done          = done_q;
    assign frame_err     = frame_err_q;
    assign rx_data       = rx_data_q;
    assign byte_cnt      = byte_cnt_q;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Scenario bench for uart_mem_loader: serial stimulus, dword model and write scoreboard.
module tb_uart_mem_loader;
    import uart_mem_loader_pkg::*;

    localparam int N   = 64;
    localparam int L   = 2;
    localparam int CPB = 16;

    // ---------------- clock / reset ----------------
    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic load_en = 1'b0;
    logic rx      = 1'b1;

    logic        cpu_hold, done, frame_err;
    logic [7:0]  rx_data;
    logic [15:0] byte_cnt;
    rx_state_e   dbg_rx_state;

    always #5 clk = ~clk;

    uart_mem_loader_if #(.N(N)) mem_if ();

    uart_mem_loader #(
        .N(N), .L(L), .CLKS_PER_BIT(CPB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_en     (load_en),
        .rx          (rx),
        .mem         (mem_if.master),
        .cpu_hold    (cpu_hold),
        .done        (done),
        .frame_err   (frame_err),
        .rx_data     (rx_data),
        .byte_cnt    (byte_cnt),
        .dbg_rx_state(dbg_rx_state)
    );

    // ---------------- scoreboard / model ----------------
    int checks = 0;
    int errors = 0;
    int writes_seen = 0;
    logic [N-1:0] exp_q[$];
    logic [N-1:0] exp_addr_q[$];

    logic [N-1:0] m_pack;
    int           m_lane, m_wr;
    bit           m_done, m_loading;
    logic [15:0]  m_cnt;
    logic [7:0]   m_last;

    function automatic void model_accept(input logic [7:0] b);
        if (m_loading && !m_done) begin
            m_last = b;
            m_cnt  = m_cnt + 16'd1;
            m_pack[(7 - m_lane) * 8 +: 8] = b;
            if (m_lane == 7) begin
                exp_q.push_back(m_pack);
                exp_addr_q.push_back(64'(m_wr * 8));
                m_wr++;
                if (m_wr == L) m_done = 1'b1;
                m_lane = 0;
                m_pack = '0;
            end else begin
                m_lane++;
            end
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n && mem_if.memwrite !== MW_NONE) begin
            writes_seen++;
            checks++;
            if (mem_if.memwrite !== MW_DWORD) begin
                errors++;
                $display("FAIL memwrite_code: got %b expected %b", mem_if.memwrite, MW_DWORD);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_if.dataadr, mem_if.writedata);
            end else begin
                logic [N-1:0] e_d, e_a;
                e_d = exp_q.pop_front();
                e_a = exp_addr_q.pop_front();
                if (mem_if.writedata !== e_d) begin
                    errors++;
                    $display("FAIL writedata: got %h expected %h", mem_if.writedata, e_d);
                end
                checks++;
                if (mem_if.dataadr !== e_a) begin
                    errors++;
                    $display("FAIL dataadr: got %h expected %h", mem_if.dataadr, e_a);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b, input logic stop_v, input int stop_clks);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_v;
        repeat (stop_clks) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send_good(input logic [7:0] b);
        model_accept(b);
        send_byte(b, 1'b1, CPB);
    endtask

    task automatic start_load();
        @(negedge clk);
        load_en = 1'b0;
        m_loading = 1'b0;
        repeat (2) @(negedge clk);
        load_en   = 1'b1;
        m_loading = 1'b1;
        m_lane = 0; m_pack = '0; m_wr = 0; m_done = 1'b0; m_cnt = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 4 * CPB && exp_q.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d pending writes expected 0", name, exp_q.size());
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; load_en = 1'b0; rx = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (mem_if.dataadr !== '0) begin errors++; $display("FAIL reset_dataadr: got %h expected 0", mem_if.dataadr); end
        checks++; if (mem_if.writedata !== '0) begin errors++; $display("FAIL reset_writedata: got %h expected 0", mem_if.writedata); end
        checks++; if (mem_if.memwrite !== 2'b00) begin errors++; $display("FAIL reset_memwrite: got %b expected 00", mem_if.memwrite); end
        checks++; if ({cpu_hold, done, frame_err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {cpu_hold, done, frame_err}); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
        checks++; if (byte_cnt !== 16'd0) begin errors++; $display("FAIL reset_byte_cnt: got %0d expected 0", byte_cnt); end
        checks++; if (dbg_rx_state !== RX_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_rx_state, RX_IDLE); end
        rst_n = 1'b1;
        m_last = '0;
        repeat (3) @(negedge clk);
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL idle_hold: got %b expected 0", cpu_hold); end
    endtask

    task automatic test_single_dword();
        int ws0;
        start_load();
        ws0 = writes_seen;
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL load_hold: got %b expected 1", cpu_hold); end
        for (int b = 1; b <= 8; b++) send_good(8'(b));
        wait_drain("single");
        checks++; if (writes_seen - ws0 !== 1) begin errors++; $display("FAIL single_writes: got %0d expected 1", writes_seen - ws0); end
        checks++; if (byte_cnt !== m_cnt) begin errors++; $display("FAIL single_byte_cnt: got %0d expected %0d", byte_cnt, m_cnt); end
        checks++; if (rx_data !== m_last) begin errors++; $display("FAIL single_rx_data: got %h expected %h", rx_data, m_last); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done: got %b expected 0", done); end
    endtask

    task automatic test_done();
        int ws0;
        ws0 = writes_seen;
        for (int b = 8'h11; b <= 8'h18; b++) send_good(8'(b));
        wait_drain("done");
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_set: got %b expected 1", done); end
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL done_hold: got %b expected 0", cpu_hold); end
        send_good(8'h99);
        repeat (2 * CPB) @(negedge clk);
        checks++; if (byte_cnt !== 16'd16) begin errors++; $display("FAIL done_ignore_cnt: got %0d expected 16", byte_cnt); end
        checks++; if (rx_data !== 8'h18) begin errors++; $display("FAIL done_ignore_data: got %h expected 18", rx_data); end
        checks++; if (writes_seen - ws0 !== 1) begin errors++; $display("FAIL done_writes: got %0d expected 1", writes_seen - ws0); end
    endtask

    task automatic test_frame_err();
        int ws0;
        start_load();
        ws0 = writes_seen;
        checks++; if ({done, frame_err, byte_cnt} !== 18'd0) begin errors++; $display("FAIL restart_clear: got %h expected 0", {done, frame_err, byte_cnt}); end
        send_byte(8'h55, 1'b0, CPB);
        repeat (2 * CPB) @(negedge clk);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_set: got %b expected 1", frame_err); end
        checks++; if (byte_cnt !== 16'd0) begin errors++; $display("FAIL ferr_cnt: got %0d expected 0", byte_cnt); end
        checks++; if (rx_data !== m_last) begin errors++; $display("FAIL ferr_rx_data: got %h expected %h", rx_data, m_last); end
        for (int i = 0; i < 8; i++) send_good(8'($urandom_range(0, 255)));
        wait_drain("ferr");
        checks++; if (writes_seen - ws0 !== 1) begin errors++; $display("FAIL ferr_writes: got %0d expected 1", writes_seen - ws0); end
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_sticky: got %b expected 1", frame_err); end
    endtask

    task automatic test_glitch();
        start_load();
        @(negedge clk);
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        checks++; if (byte_cnt !== 16'd0) begin errors++; $display("FAIL glitch_cnt: got %0d expected 0", byte_cnt); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL glitch_ferr: got %b expected 0", frame_err); end
        checks++; if (dbg_rx_state !== RX_IDLE) begin errors++; $display("FAIL glitch_state: got %0d expected %0d", dbg_rx_state, RX_IDLE); end
    endtask

    task automatic test_abort();
        int ws0;
        ws0 = writes_seen;
        for (int i = 0; i < 5; i++) send_good(8'($urandom_range(0, 255)));
        @(negedge clk);
        rx = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        load_en = 1'b0;
        m_loading = 1'b0; m_lane = 0; m_pack = '0;
        repeat (2) @(negedge clk);
        checks++; if (dbg_rx_state !== RX_IDLE) begin errors++; $display("FAIL abort_state: got %0d expected %0d", dbg_rx_state, RX_IDLE); end
        rx = 1'b1;
        repeat (8 * CPB) @(negedge clk);
        checks++; if (writes_seen - ws0 !== 0) begin errors++; $display("FAIL abort_no_write: got %0d expected 0", writes_seen - ws0); end
        start_load();
        for (int i = 0; i < 8; i++) send_good(8'h30 + 8'(i));
        wait_drain("abort");
        checks++; if (writes_seen - ws0 !== 1) begin errors++; $display("FAIL abort_writes: got %0d expected 1", writes_seen - ws0); end
    endtask

    task automatic test_back_to_back();
        int ws0;
        start_load();
        ws0 = writes_seen;
        for (int i = 0; i < 7; i++) send_good(8'($urandom_range(0, 255)));
        model_accept(8'hA7);
        send_byte(8'hA7, 1'b1, CPB / 2 + 4);
        for (int i = 0; i < 8; i++) send_good(8'($urandom_range(0, 255)));
        wait_drain("b2b");
        checks++; if (writes_seen - ws0 !== 2) begin errors++; $display("FAIL b2b_writes: got %0d expected 2", writes_seen - ws0); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b expected 1", done); end
        checks++; if (byte_cnt !== 16'd16) begin errors++; $display("FAIL b2b_cnt: got %0d expected 16", byte_cnt); end
    endtask

    task automatic test_reset_mid();
        int ws0;
        start_load();
        for (int i = 0; i < 3; i++) send_good(8'($urandom_range(0, 255)));
        @(negedge clk);
        rx = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        checks++; if (dbg_rx_state !== RX_DATA) begin errors++; $display("FAIL mid_pre_state: got %0d expected %0d", dbg_rx_state, RX_DATA); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if ({mem_if.dataadr, mem_if.writedata, mem_if.memwrite} !== '0) begin errors++; $display("FAIL mid_reset_bus: got %h expected 0", {mem_if.dataadr, mem_if.writedata, mem_if.memwrite}); end
        checks++; if ({cpu_hold, done, frame_err, rx_data, byte_cnt} !== '0) begin errors++; $display("FAIL mid_reset_status: got %h expected 0", {cpu_hold, done, frame_err, rx_data, byte_cnt}); end
        checks++; if (dbg_rx_state !== RX_IDLE) begin errors++; $display("FAIL mid_reset_state: got %0d expected %0d", dbg_rx_state, RX_IDLE); end
        rx = 1'b1;
        m_lane = 0; m_pack = '0; m_wr = 0; m_done = 1'b0; m_cnt = '0; m_last = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        ws0 = writes_seen;
        for (int i = 0; i < 8; i++) send_good(8'hC0 + 8'(i));
        wait_drain("mid");
        checks++; if (writes_seen - ws0 !== 1) begin errors++; $display("FAIL mid_writes: got %0d expected 1", writes_seen - ws0); end
        checks++; if (byte_cnt !== m_cnt) begin errors++; $display("FAIL mid_cnt: got %0d expected %0d", byte_cnt, m_cnt); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        m_pack = '0; m_lane = 0; m_wr = 0; m_done = 1'b0;
        m_loading = 1'b0; m_cnt = '0; m_last = '0;
        test_reset();
        test_single_dword();
        test_done();
        test_frame_err();
        test_glitch();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
